ex_divider: RTL and testbench
=============================

EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk_i  input  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  EX-stage divide request; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 SHALL have port rs1_val_i  input  XLEN  dividend, post-forwarding EX operand A.
REQ-007 SHALL have port rs2_val_i  input  XLEN  divisor, post-forwarding EX operand B.
REQ-008 SHALL have port flush_i  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port busy_o  output  1  high while state is CALC.
REQ-010 SHALL have port stall_o  output  1  combinational stall request to the pipeline.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse; result_o valid.
REQ-012 SHALL have port result_o  output  XLEN  quotient or remainder selected by the latched op.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE.
REQ-014 IDLE with start_i=1 and flush_i=0 SHALL latch op_i and both operands.
REQ-015 Divisor==0 or signed overflow SHALL go IDLE->DONE; otherwise IDLE->CALC.
REQ-016 CALC SHALL run exactly XLEN cycles of radix-2 restoring division on the operand magnitudes.
REQ-017 An iteration counter SHALL load XLEN-1 on entry and CALC->DONE SHALL occur when it reaches 0.
REQ-018 DONE SHALL last one cycle, assert done_o and drive result_o, then go to IDLE.
REQ-019 Latency, with start accepted at cycle 0: normal case done_o at cycle XLEN+1; special cases done_o at cycle 1.
REQ-020 stall_o SHALL = (IDLE & start_i & ~flush_i) | CALC, and SHALL be low in DONE so the instruction advances with its result.
REQ-021 DIV/REM SHALL divide magnitudes.
REQ-022 The quotient SHALL be negated when the operand signs differ.
REQ-023 The remainder SHALL take the sign of the dividend.
REQ-024 DIVU/REMU SHALL treat operands as unsigned.
REQ-025 Divide by zero SHALL give quotient all-ones (both signednesses) and remainder = dividend.
REQ-026 Overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-027 start_i in CALC or DONE SHALL be ignored; the latched operands and op SHALL not change.
REQ-028 flush_i SHALL force IDLE next cycle from any state with no done_o pulse, and SHALL override a simultaneous start_i.
REQ-029 result_o SHALL hold its last value until the next DONE.

Reset
REQ-030 reset_i SHALL, at the next edge and from any state including mid-CALC, force:
  - state IDLE;
  - counter 0;
  - latched operands 0;
  - result_o 0;
  - done_o 0.
REQ-031 After that reset edge, busy_o and stall_o SHALL be 0 while start_i is 0.
REQ-032 reset_i SHALL have priority over flush_i and start_i.

Structure
REQ-033 A shared core package SHALL hold:
  - the op_i encodings;
  - the state encoding;
  - the XLEN default;
  - the iteration-count constant.
REQ-034 One combinational sub-module div_step SHALL implement a single restoring shift/subtract step: partial remainder, divisor and next dividend bit in; new remainder and quotient bit out.

Verification
REQ-035 DIVU 100/7 at cycle 0 -> stall_o high cycles 0..32, done_o at cycle 33, result 14; REMU same operands -> 2.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-037 DIVU 5/0 -> 0xFFFFFFFF with done_o at cycle 1; REM 5/0 -> 5; busy_o never high.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
REQ-039 Flush scenario:
  - flush_i at cycle 10 of a DIVU -> no done_o, busy_o low from cycle 11;
  - new start at cycle 11 completes correctly.
REQ-040 Ignored-start and reset scenario:
  - start_i pulsed with different operands during CALC -> original result delivered;
  - reset_i mid-CALC -> result_o 0, IDLE next cycle.

Source files
------------

// File: rtl/ex_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider: op encodings, FSM
// states, default width and the iteration-count constant.
package ex_divider_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Iterations performed after the load cycle; counter counts down to zero.
  localparam int ITER_COUNT_DEFAULT = XLEN_DEFAULT - 1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int iter_count(input int xlen);
    return xlen - 1;
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_divider_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted_s;

  // The partial remainder is always below the divisor, so the true difference
  // fits XLEN bits and the truncated subtraction is exact.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      q_bit_o = 1'b1;
      rem_o   = shifted_s[XLEN-1:0] - divisor_i;
    end else begin
      q_bit_o = 1'b0;
      rem_o   = shifted_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_divider.sv
// Iterative EX-stage divider for DIV/DIVU/REM/REMU; one quotient bit per cycle
// on operand magnitudes, with divide-by-zero and overflow resolved at issue.
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(iter_count(XLEN));
  localparam logic [XLEN-1:0] ZERO_W    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_W     = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;     // dividend magnitude shifts out, quotient shifts in
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             done_q, done_d;

  op_e              op_in_s;
  logic             in_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_mag_s;
  logic [XLEN-1:0]  b_mag_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN-1:0]  step_rem_s;
  logic             step_q_s;
  logic [XLEN-1:0]  quo_next_s;
  logic [XLEN-1:0]  calc_res_s;

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[XLEN-1]),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  // Issue-time decode: operand magnitudes and the two cases that skip CALC.
  always_comb begin
    op_in_s     = op_e'(op_i);
    in_signed_s = is_signed_op(op_in_s);
    a_neg_s     = in_signed_s & rs1_val_i[XLEN-1];
    b_neg_s     = in_signed_s & rs2_val_i[XLEN-1];
    a_mag_s     = a_neg_s ? (ZERO_W - rs1_val_i) : rs1_val_i;
    b_mag_s     = b_neg_s ? (ZERO_W - rs2_val_i) : rs2_val_i;
    div_zero_s  = (rs2_val_i == ZERO_W);
    overflow_s  = in_signed_s & (rs1_val_i == MIN_W) & (rs2_val_i == ONES_W);
    if (div_zero_s) begin
      special_res_s = is_rem_op(op_in_s) ? rs1_val_i : ONES_W;
    end else begin
      special_res_s = is_rem_op(op_in_s) ? ZERO_W : MIN_W;
    end
  end

  // Final sign fix-up applied to the outputs of the last division step.
  always_comb begin
    quo_next_s = {dvd_q[XLEN-2:0], step_q_s};
    if (is_rem_op(op_q)) begin
      calc_res_s = r_neg_q ? (ZERO_W - step_rem_s) : step_rem_s;
    end else begin
      calc_res_s = q_neg_q ? (ZERO_W - quo_next_s) : quo_next_s;
    end
  end

  // Next-state logic; flush beats any pending start or completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d    = op_in_s;
            dvd_d   = a_mag_s;
            dvs_d   = b_mag_s;
            rem_d   = ZERO_W;
            q_neg_d = a_neg_s ^ b_neg_s;
            r_neg_d = a_neg_s;
            if (div_zero_s || overflow_s) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = special_res_s;
            end else begin
              state_d = ST_CALC;
              cnt_d   = ITER_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_d = step_rem_s;
          dvd_d = quo_next_s;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = calc_res_s;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_DIV;
      dvd_q    <= ZERO_W;
      dvs_q    <= ZERO_W;
      rem_q    <= ZERO_W;
      cnt_q    <= {CNT_W{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= ZERO_W;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == ST_CALC);
  assign stall_o  = ((state_q == ST_IDLE) & start_i & ~flush_i) | (state_q == ST_CALC);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed corner cases, randomized
// operations against an arithmetic reference, flush, ignored-start and reset.
module tb_ex_divider;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_val_i;
  logic [31:0] rs2_val_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  ex_divider #(.XLEN(32)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_val_i (rs1_val_i),
    .rs2_val_i (rs2_val_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return 32'(sa / sb);
      2'd1:    return 32'(ua / ub);
      2'd2:    return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Caller must be positioned just after a falling edge; that cycle is cycle 0.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp_res;
    int exp_lat;
    int cyc;
    bit bad_pipe;
    exp_res  = ref_div(op, a, b);
    exp_lat  = is_special(op, a, b) ? 1 : 33;
    bad_pipe = 1'b0;
    start_i = 1'b1; op_i = op; rs1_val_i = a; rs2_val_i = b;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_c0: got %b want 1", name, stall_o);
    end
    @(negedge clk_i);
    start_i = 1'b0; rs1_val_i = $urandom; rs2_val_i = $urandom; op_i = 2'($urandom);
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 40) begin
      if (stall_o !== 1'b1 || busy_o !== 1'b1) bad_pipe = 1'b1;
      @(negedge clk_i);
      cyc++;
    end
    checks++;
    if (bad_pipe) begin
      errors++;
      $display("FAIL %s stall_busy_calc: stall/busy low before done", name);
    end
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++;
      $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", name, op, a, b, result_o, exp_res);
    end
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: stall=%b busy=%b want 0 0", name, stall_o, busy_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_i = 2'd1;
    rs1_val_i = 32'd100; rs2_val_i = 32'd7;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0; start_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall=%b done=%b result=%h want 0 0 0 0",
               busy_o, stall_o, done_o, result_o);
    end
  endtask

  task automatic test_directed();
    @(negedge clk_i); do_div(2'd1, 32'd100, 32'd7, "divu_100_7");
    @(negedge clk_i); do_div(2'd3, 32'd100, 32'd7, "remu_100_7");
    @(negedge clk_i); do_div(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    @(negedge clk_i); do_div(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    @(negedge clk_i); do_div(2'd0, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    @(negedge clk_i); do_div(2'd1, 32'd5, 32'd0, "divu_by0");
    @(negedge clk_i); do_div(2'd0, 32'd5, 32'd0, "div_by0");
    @(negedge clk_i); do_div(2'd2, 32'd5, 32'd0, "rem_by0");
    @(negedge clk_i); do_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    @(negedge clk_i); do_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    @(negedge clk_i); do_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    @(negedge clk_i); do_div(2'd3, 32'hFFFF_FFFF, 32'd1, "remu_max_1");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 300));
        2:       b = 32'd0;
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
      endcase
      @(negedge clk_i);
      do_div(2'($urandom), a, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); do_div(2'd0, 32'hFFFF_FF00, 32'd16, "b2b_1");
    @(negedge clk_i); do_div(2'd3, 32'd12345, 32'd0, "b2b_2");
    @(negedge clk_i); do_div(2'd2, 32'd12345, 32'hFFFF_FF9C, "b2b_3");
  endtask

  task automatic test_result_hold();
    logic [31:0] held;
    bit bad;
    @(negedge clk_i); do_div(2'd1, 32'd999, 32'd10, "hold_setup");
    held = 32'd99;
    bad  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || result_o !== held) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL result_hold: result=%h done=%b want %h 0", result_o, done_o, held);
    end
  endtask

  task automatic test_flush();
    bit saw_done;
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd1; rs1_val_i = 32'd50; rs2_val_i = 32'd3;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got %b want 0", stall_o);
    end
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start: busy=%b done=%b want 0 0", busy_o, done_o);
    end
    start_i = 1'b1; op_i = 2'd1; rs1_val_i = 32'd1000; rs2_val_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done_o !== 1'b0) saw_done = 1'b1;
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    if (done_o !== 1'b0) saw_done = 1'b1;
    checks++;
    if (saw_done || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: saw_done=%b busy=%b want 0 0", saw_done, busy_o);
    end
    do_div(2'd3, 32'd77, 32'd5, "after_flush");
  endtask

  task automatic test_ignored_start();
    int cyc;
    start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'd1; rs1_val_i = 32'd4000; rs2_val_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0; cyc = 1;
    while (cyc < 5) begin @(negedge clk_i); cyc++; end
    start_i = 1'b1; op_i = 2'd2; rs1_val_i = 32'd17; rs2_val_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0; cyc++;
    while (done_o !== 1'b1 && cyc < 40) begin @(negedge clk_i); cyc++; end
    checks++;
    if (cyc != 33 || result_o !== 32'd444) begin
      errors++;
      $display("FAIL ignored_start: lat=%0d result=%h want 33 %h", cyc, result_o, 32'd444);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'd0; rs1_val_i = 32'hFFFF_0000; rs2_val_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    reset_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (result_o !== 32'd0 || busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: result=%h busy=%b stall=%b done=%b want 0 0 0 0",
               result_o, busy_o, stall_o, done_o);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done pulse want none");
    end
    @(negedge clk_i); do_div(2'd2, 32'hFFFF_0000, 32'd3, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_result_hold();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
